// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier datapath: output-RAM word
// layout, sweep geometry and the result-expander state encoding.
package approx_mult_pkg;

  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MANT_LSB  = 0;
  localparam int unsigned MANT_W    = 16;
  localparam int unsigned SHAMT_LSB = 16;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned OUT_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    EMIT,
    DONE
  } expState_e;

endpackage

// File: rtl/serial_lshift_unit.sv
// Serial left shifter: 32-bit accumulator, shift counter and sticky overflow.
// Next-state values are exported so the parent can capture results on entry to EMIT.
module serial_lshift_unit
  import approx_mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [MANT_W-1:0]  mant,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [OUT_W-1:0]   accNext_c,
  output logic               ovfNext_c,
  output logic               last_c,
  output logic               zero_c
);

  logic [OUT_W-1:0]   acc;
  logic               ovf;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cntNext;

  // Load takes priority; a step shifts one bit and remembers anything leaving the top.
  always_comb begin
    accNext_c = acc;
    ovfNext_c = ovf;
    cntNext   = cnt;
    if (load) begin
      accNext_c = OUT_W'(mant);
      ovfNext_c = 1'b0;
      cntNext   = shamt;
    end else if (step) begin
      accNext_c = {acc[OUT_W-2:0], 1'b0};
      ovfNext_c = ovf | acc[OUT_W-1];
      cntNext   = cnt - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      acc <= accNext_c;
      ovf <= ovfNext_c;
      cnt <= cntNext;
    end
  end

  assign last_c = (cnt == SHAMT_W'(1));
  // While loading, the counter is stale; report on the incoming amount instead.
  assign zero_c = load ? (shamt == '0) : (cnt == '0);

endmodule

// File: rtl/approx_result_expander.sv
// Sweeps the multiplier output RAM and rebuilds each 32-bit product by serial left shift.
// Optional macro APPROX_EXPAND_SATURATE_EN: overflowed results read as all-ones.
module approx_result_expander
  import approx_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_ovf
);

  expState_e          state;
  expState_e          stateNext;
  logic [ADDR_W-1:0]  addrNext;
  logic               load;
  logic               step;
  logic               last_c;
  logic               zero_c;
  logic               ovfNext_c;
  logic [OUT_W-1:0]   accNext_c;
  logic [OUT_W-1:0]   dataNext;
  logic [MANT_W-1:0]  mant;
  logic [SHAMT_W-1:0] shamt;
  logic               unusedHigh;

  assign mant       = rd_data[MANT_LSB +: MANT_W];
  assign shamt      = rd_data[SHAMT_LSB +: SHAMT_W];
  assign unusedHigh = ^rd_data[WORD_W-1:SHAMT_LSB+SHAMT_W];

  serial_lshift_unit u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .mant      (mant),
    .shamt     (shamt),
    .accNext_c (accNext_c),
    .ovfNext_c (ovfNext_c),
    .last_c    (last_c),
    .zero_c    (zero_c)
  );

  // Sweep control; rd_addr doubles as the address counter and is zero whenever idle.
  always_comb begin
    stateNext = state;
    addrNext  = rd_addr;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addrNext  = '0;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        load      = 1'b1;
        stateNext = zero_c ? EMIT : SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (last_c) stateNext = EMIT;
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (rd_addr == ADDR_W'(DEPTH - 1)) begin
            stateNext = DONE;
          end else begin
            addrNext  = rd_addr + ADDR_W'(1);
            stateNext = FETCH;
          end
        end
      end
      DONE: begin
        addrNext  = '0;
        stateNext = IDLE;
      end
      default: begin
        addrNext  = '0;
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
`ifdef APPROX_EXPAND_SATURATE_EN
    dataNext = ovfNext_c ? '1 : accNext_c;
`else
    dataNext = accNext_c;
`endif
  end

  // Outputs are captured from next-state values so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= stateNext;
      rd_addr   <= addrNext;
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
      out_valid <= (stateNext == EMIT);
      if (stateNext == EMIT) begin
        out_data <= dataNext;
        out_idx  <= addrNext;
        out_ovf  <= ovfNext_c;
      end else begin
        out_data <= '0;
        out_idx  <= '0;
        out_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_result_expander.sv
// Self-checking bench for approx_result_expander with a behavioural RAM and
// a queue of expected results popped on every out_valid/out_ready handshake.
module tb_approx_result_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_ovf;

  logic [31:0] ram [8];

  typedef struct packed {
    logic        ovf;
    logic [2:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   nAssert = 0;
  int   nFail   = 0;

  always #5 clk = ~clk;

  assign rd_data = ram[rd_addr];

  approx_result_expander dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ovf   (out_ovf)
  );

  // Reference: exact 64-bit shift, truncate to 32 bits, flag any lost high bits.
  function automatic exp_t model(input logic [15:0] m, input logic [4:0] k, input logic [2:0] idx);
    logic [63:0] full;
    exp_t        e;
    full   = 64'(m) << k;
    e.data = full[31:0];
    e.ovf  = |full[63:32];
    e.idx  = idx;
`ifdef APPROX_EXPAND_SATURATE_EN
    if (e.ovf) e.data = 32'hFFFF_FFFF;
`endif
    return e;
  endfunction

  task automatic fill(input logic [15:0] m0, input logic [4:0] k0,
                      input logic [15:0] mr, input logic [4:0] kr, input bit ramp);
    logic [15:0] m;
    logic [4:0]  k;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      m = (i == 0) ? m0 : mr;
      k = ramp ? 5'(i) : ((i == 0) ? k0 : kr);
      ram[i] = {11'h5A5, k, m};
      sb.push_back(model(m, k, 3'(i)));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((busy || out_valid) && c < 60) begin
      @(negedge clk);
      c++;
    end
    nAssert++;
    if (busy) begin
      nFail++;
      $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, c);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    fill(16'h0, 5'd0, 16'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    nAssert++;
    if ({busy, done, out_valid, out_ovf, out_data, out_idx, rd_addr} !== 41'h0) begin
      nFail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b valid=%0b ovf=%0b data=%h idx=%0d addr=%0d, required all 0",
               busy, done, out_valid, out_ovf, out_data, out_idx, rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    int cyc;
    exp_t e;
    fill(16'h0051, 5'd0, 16'h1234, 5'd0, 1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    nAssert++;
    if (busy !== 1'b1) begin
      nFail++;
      $display("FAIL pass_busy: got %0b, required 1", busy);
    end
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    nAssert++;
    if (cyc != 2) begin
      nFail++;
      $display("FAIL pass_latency: got %0d cycles from start, required 2", cyc);
    end
    nAssert++;
    if ({out_ovf, out_idx, out_data} !== {1'b0, 3'd0, 32'h0000_0051}) begin
      nFail++;
      $display("FAIL pass_value: got ovf=%0b idx=%0d data=%h, required ovf=0 idx=0 data=00000051",
               out_ovf, out_idx, out_data);
    end
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL pass_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL pass_drain: got %0d results outstanding, required 0", sb.size());
    end
    wait_idle("pass");
  endtask

  task automatic test_shift_latency();
    int cyc;
    exp_t e;
    fill(16'h3C00, 5'd8, 16'h0003, 5'd3, 1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    nAssert++;
    if (cyc != 10) begin
      nFail++;
      $display("FAIL shift_latency: got %0d cycles from start, required 10", cyc);
    end
    nAssert++;
    if (out_data !== 32'h003C_0000) begin
      nFail++;
      $display("FAIL shift_value: got %h, required 003c0000", out_data);
    end
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL shift_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL shift_drain: got %0d results outstanding, required 0", sb.size());
    end
    wait_idle("shift");
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    fill(16'h00C3, 5'd2, 16'h0007, 5'd1, 1'b0);
    out_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      nAssert++;
      if ({out_valid, out_ovf, out_idx, out_data, rd_addr} !== {1'b1, sb[0], 3'd0}) begin
        nFail++;
        $display("FAIL bp_hold%0d: got valid=%0b ovf=%0b idx=%0d data=%h addr=%0d, expected valid=1 ovf=%0b idx=%0d data=%h addr=0",
                 i, out_valid, out_ovf, out_idx, out_data, rd_addr, sb[0].ovf, sb[0].idx, sb[0].data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    nAssert++;
    if ({out_ovf, out_idx, out_data} !== e) begin
      nFail++;
      $display("FAIL bp_release: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
               out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
    end
    @(negedge clk);
    nAssert++;
    if ({rd_addr, out_valid} !== {3'd1, 1'b0}) begin
      nFail++;
      $display("FAIL bp_advance: got addr=%0d valid=%0b, required addr=1 valid=0", rd_addr, out_valid);
    end
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL bp_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL bp_drain: got %0d results outstanding, required 0", sb.size());
    end
    wait_idle("bp");
  endtask

  task automatic test_overflow();
    int cyc;
    exp_t e;
    logic [31:0] want;
`ifdef APPROX_EXPAND_SATURATE_EN
    want = 32'hFFFF_FFFF;
`else
    want = 32'hFFF0_0000;
`endif
    // Entry 0 overflows; the rest sit exactly at the no-overflow boundary (k=16).
    fill(16'hFFFF, 5'd20, 16'hFFFF, 5'd16, 1'b0);
    out_ready = 1'b1;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    nAssert++;
    if ({out_ovf, out_data} !== {1'b1, want}) begin
      nFail++;
      $display("FAIL ovf_value: got ovf=%0b data=%h, required ovf=1 data=%h", out_ovf, out_data, want);
    end
    for (int c = 0; c < 600 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL ovf_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL ovf_drain: got %0d results outstanding, required 0", sb.size());
    end
    wait_idle("ovf");
  endtask

  task automatic test_full_sweep();
    int doneCnt;
    int stray;
    exp_t e;
    fill(16'h0001, 5'd0, 16'h0001, 5'd0, 1'b1);
    out_ready = 1'b1;
    doneCnt = 0;
    stray = 0;
    pulse_start();
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      if (done) doneCnt++;
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL sweep_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      start = (c == 10);
      @(negedge clk);
    end
    start = 1'b0;
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL sweep_drain: got %0d results outstanding, required 0", sb.size());
    end
    nAssert++;
    if ({done, busy, out_valid} !== 3'b110) begin
      nFail++;
      $display("FAIL sweep_done_cycle: got done=%0b busy=%0b valid=%0b, required done=1 busy=1 valid=0",
               done, busy, out_valid);
    end
    if (done) doneCnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      if (busy || out_valid) stray++;
    end
    nAssert++;
    if (doneCnt != 1) begin
      nFail++;
      $display("FAIL sweep_done_count: got %0d pulses, required 1", doneCnt);
    end
    nAssert++;
    if (stray != 0) begin
      nFail++;
      $display("FAIL sweep_after_done: got %0d busy/valid cycles after done, required 0", stray);
    end
  endtask

  task automatic test_reset_midsweep();
    exp_t e;
    fill(16'h00AB, 5'd10, 16'h00AB, 5'd10, 1'b0);
    out_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL rst_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      if (rd_addr == 3'd3 && !out_valid) break;
      @(negedge clk);
    end
    nAssert++;
    if (rd_addr !== 3'd3) begin
      nFail++;
      $display("FAIL rst_reach_entry3: got addr=%0d, required 3", rd_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nAssert++;
    if ({busy, done, out_valid, out_ovf, out_data, out_idx, rd_addr} !== 41'h0) begin
      nFail++;
      $display("FAIL rst_mid_outputs: got busy=%0b done=%0b valid=%0b ovf=%0b data=%h idx=%0d addr=%0d, required all 0",
               busy, done, out_valid, out_ovf, out_data, out_idx, rd_addr);
    end
    rst = 1'b1;
    fill(16'h00AB, 5'd10, 16'h00AB, 5'd10, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nAssert++;
    if ({busy, rd_addr} !== {1'b1, 3'd0}) begin
      nFail++;
      $display("FAIL rst_restart: got busy=%0b addr=%0d, required busy=1 addr=0", busy, rd_addr);
    end
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        nAssert++;
        if ({out_ovf, out_idx, out_data} !== e) begin
          nFail++;
          $display("FAIL rst_restart_sb: got ovf=%0b idx=%0d data=%h, expected ovf=%0b idx=%0d data=%h",
                   out_ovf, out_idx, out_data, e.ovf, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    nAssert++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL rst_restart_drain: got %0d results outstanding, required 0", sb.size());
    end
    wait_idle("rst");
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_shift_latency();
    test_backpressure();
    test_overflow();
    test_full_sweep();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
